// File: rtl/cpu_periph_pkg.sv
// Shared constants for the CPU peripheral slice: RX buffer FSM encodings and UART timing.
package cpu_periph_pkg;

    localparam logic [1:0] RXB_IDLE    = 2'd0;
    localparam logic [1:0] RXB_COUNT   = 2'd1;
    localparam logic [1:0] RXB_EXPIRED = 2'd2;

    localparam int UART_CLKS_PER_BIT = 10416;
    // Two bit-times of silence after the last byte counts as end of burst.
    localparam int RXB_TIMEOUT_DEF   = 2 * UART_CLKS_PER_BIT;

endpackage

// File: rtl/sync_fifo_mem.sv
// DEPTH x DATA_W register array: synchronous write port, asynchronous read port.
// Contents are not reset.
module sync_fifo_mem #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic              i_clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [2**ADDR_W];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/uart_rx_buffer.sv
// Receive-side show-ahead byte FIFO between uart_rx and the peripheral registers,
// with sticky overflow and a level IRQ on fill threshold or idle timeout.
module uart_rx_buffer
    import cpu_periph_pkg::*;
#(
    parameter int ADDR_W  = 4,
    parameter int THRESH  = 8,
    parameter int TIMEOUT = RXB_TIMEOUT_DEF
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_rx_dv,
    input  logic [7:0]        i_rx_byte,
    input  logic              i_rd,
    input  logic              i_irq_en,
    input  logic              i_clr,
    output logic [7:0]        o_rx_data,
    output logic [ADDR_W:0]   o_rx_count,
    output logic              o_rx_empty,
    output logic              o_rx_full,
    output logic              o_rx_ovf,
    output logic              o_rx_irq
);

    localparam int DEPTH = 2**ADDR_W;
    localparam int CNT_W = $clog2(TIMEOUT) + 1;

    localparam logic [ADDR_W:0] C_DEPTH  = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] C_THRESH = (ADDR_W+1)'(THRESH);
    localparam logic [CNT_W-1:0] C_LAST  = CNT_W'(TIMEOUT - 1);

    logic [ADDR_W-1:0] r_wp;
    logic [ADDR_W-1:0] r_rp;
    logic [ADDR_W:0]   r_count;
    logic              r_ovf;
    logic              r_to_flag;
    logic [1:0]        r_state;
    logic [CNT_W-1:0]  r_idle_cnt;
    logic              r_irq;

    logic              w_empty;
    logic              w_full;
    logic              w_push;
    logic              w_pop;
    logic              w_drop;
    logic [ADDR_W:0]   w_count_nxt;
    logic              w_drained;
    logic [7:0]        w_mem_rdata;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == C_DEPTH);
    assign w_pop   = i_rd & ~w_empty;
    // At full, a same-cycle pop frees the slot the push lands in.
    assign w_push  = i_rx_dv & (~w_full | i_rd);
    assign w_drop  = i_rx_dv & w_full & ~i_rd;

    always_comb begin
        w_count_nxt = r_count;
        if (w_push && !w_pop) begin
            w_count_nxt = r_count + 1'b1;
        end else if (w_pop && !w_push) begin
            w_count_nxt = r_count - 1'b1;
        end
    end

    assign w_drained = (w_count_nxt == '0);

    sync_fifo_mem #(
        .ADDR_W (ADDR_W),
        .DATA_W (8)
    ) u_mem (
        .i_clk   (i_clk),
        .i_we    (w_push),
        .i_waddr (r_wp),
        .i_wdata (i_rx_byte),
        .i_raddr (r_rp),
        .o_rdata (w_mem_rdata)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
        end else begin
            if (w_push) begin
                r_wp <= r_wp + 1'b1;
            end
            if (w_pop) begin
                r_rp <= r_rp + 1'b1;
            end
            r_count <= w_count_nxt;
            if (w_drop) begin
                r_ovf <= 1'b1;
            end else if (i_clr) begin
                r_ovf <= 1'b0;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= RXB_IDLE;
            r_idle_cnt <= '0;
            r_to_flag  <= 1'b0;
        end else begin
            case (r_state)
                RXB_IDLE: begin
                    if (w_push) begin
                        r_state    <= RXB_COUNT;
                        r_idle_cnt <= '0;
                    end
                end
                RXB_COUNT: begin
                    if (w_push) begin
                        r_idle_cnt <= '0;
                    end else if (w_drained) begin
                        r_state <= RXB_IDLE;
                    end else if (r_idle_cnt == C_LAST) begin
                        r_state   <= RXB_EXPIRED;
                        r_to_flag <= 1'b1;
                    end else if (r_idle_cnt != '1) begin
                        r_idle_cnt <= r_idle_cnt + 1'b1;
                    end
                end
                RXB_EXPIRED: begin
                    if (w_push) begin
                        r_state    <= RXB_COUNT;
                        r_idle_cnt <= '0;
                        r_to_flag  <= 1'b0;
                    end else if (i_clr || w_drained) begin
                        r_state   <= RXB_IDLE;
                        r_to_flag <= 1'b0;
                    end
                end
                default: begin
                    r_state   <= RXB_IDLE;
                    r_to_flag <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_irq <= 1'b0;
        end else begin
            r_irq <= ((r_count >= C_THRESH) | r_to_flag) & i_irq_en;
        end
    end

    assign o_rx_data  = w_empty ? 8'h00 : w_mem_rdata;
    assign o_rx_count = r_count;
    assign o_rx_empty = w_empty;
    assign o_rx_full  = w_full;
    assign o_rx_ovf   = r_ovf;
    assign o_rx_irq   = r_irq;

endmodule

// File: tb/tb_uart_rx_buffer.sv
// Directed bench for uart_rx_buffer: queue-based reference model checked every cycle,
// plus literal expectations per scenario.
module tb_uart_rx_buffer;

    localparam int TO     = 20832;
    localparam int DEPTH  = 16;
    localparam int THRESH = 8;

    logic       i_clk = 1'b0;
    logic       i_rst_n = 1'b0;
    logic       i_rx_dv = 1'b0;
    logic [7:0] i_rx_byte = 8'h00;
    logic       i_rd = 1'b0;
    logic       i_irq_en = 1'b0;
    logic       i_clr = 1'b0;
    logic [7:0] o_rx_data;
    logic [4:0] o_rx_count;
    logic       o_rx_empty;
    logic       o_rx_full;
    logic       o_rx_ovf;
    logic       o_rx_irq;

    int total = 0;
    int bad   = 0;

    uart_rx_buffer #(
        .ADDR_W  (4),
        .THRESH  (THRESH),
        .TIMEOUT (TO)
    ) dut (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_rx_dv    (i_rx_dv),
        .i_rx_byte  (i_rx_byte),
        .i_rd       (i_rd),
        .i_irq_en   (i_irq_en),
        .i_clr      (i_clr),
        .o_rx_data  (o_rx_data),
        .o_rx_count (o_rx_count),
        .o_rx_empty (o_rx_empty),
        .o_rx_full  (o_rx_full),
        .o_rx_ovf   (o_rx_ovf),
        .o_rx_irq   (o_rx_irq)
    );

    always #5 i_clk = ~i_clk;

    // Reference model: byte queue, sticky overflow, "cycles since last accepted push" timer.
    logic [7:0] mq[$];
    bit         m_ovf   = 1'b0;
    bit         m_to    = 1'b0;
    bit         m_armed = 1'b0;
    int         m_since = 0;
    bit         m_irq   = 1'b0;

    task automatic model_step();
        int  sz;
        bit  push;
        bit  pop;
        bit  irq_n;
        if (!i_rst_n) begin
            mq.delete();
            m_ovf   = 1'b0;
            m_to    = 1'b0;
            m_armed = 1'b0;
            m_since = 0;
            m_irq   = 1'b0;
        end else begin
            sz    = mq.size();
            irq_n = ((sz >= THRESH) || m_to) && i_irq_en;
            pop   = i_rd && (sz > 0);
            push  = i_rx_dv && ((sz < DEPTH) || i_rd);
            if (i_rx_dv && (sz == DEPTH) && !i_rd) m_ovf = 1'b1;
            else if (i_clr) m_ovf = 1'b0;
            if (pop) void'(mq.pop_front());
            if (push) mq.push_back(i_rx_byte);
            if (push) begin
                m_armed = 1'b1;
                m_since = 0;
                m_to    = 1'b0;
            end else if (m_armed) begin
                if (mq.size() == 0) begin
                    m_armed = 1'b0;
                end else begin
                    m_since++;
                    if (m_since == TO) begin
                        m_to    = 1'b1;
                        m_armed = 1'b0;
                    end
                end
            end else if (m_to && (i_clr || mq.size() == 0)) begin
                m_to = 1'b0;
            end
            m_irq = irq_n;
        end
    endtask

    always @(posedge i_clk or negedge i_rst_n) model_step();

    logic [7:0] exp_data;
    logic [4:0] exp_count;

    always @(negedge i_clk) begin
        exp_data  = (mq.size() > 0) ? mq[0] : 8'h00;
        exp_count = 5'(mq.size());
        total++;
        if (o_rx_data !== exp_data || o_rx_count !== exp_count ||
            o_rx_empty !== (exp_count == 0) || o_rx_full !== (exp_count == 5'd16) ||
            o_rx_ovf !== m_ovf || o_rx_irq !== m_irq) begin
            bad++;
            $display("FAIL model t=%0t got data=%h cnt=%0d emp=%b full=%b ovf=%b irq=%b required data=%h cnt=%0d ovf=%b irq=%b",
                     $time, o_rx_data, o_rx_count, o_rx_empty, o_rx_full, o_rx_ovf, o_rx_irq,
                     exp_data, exp_count, m_ovf, m_irq);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic step(input logic dv, input logic [7:0] b, input logic rd, input logic clr);
        i_rx_dv   = dv;
        i_rx_byte = b;
        i_rd      = rd;
        i_clr     = clr;
        @(negedge i_clk);
        i_rx_dv = 1'b0;
        i_rd    = 1'b0;
        i_clr   = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge i_clk);
    endtask

    initial begin
        repeat (2) @(negedge i_clk);
        chk("rst_count", 32'(o_rx_count), 0);
        chk("rst_empty", 32'(o_rx_empty), 1);
        chk("rst_data",  32'(o_rx_data), 0);
        i_rst_n = 1'b1;

        // 1: reset mid-burst
        for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h11 + i), 1'b0, 1'b0);
        chk("t1_count5", 32'(o_rx_count), 5);
        #2 i_rst_n = 1'b0;
        #1;
        chk("t1_rst_count", 32'(o_rx_count), 0);
        chk("t1_rst_empty", 32'(o_rx_empty), 1);
        chk("t1_rst_data",  32'(o_rx_data), 0);
        chk("t1_rst_irq",   32'(o_rx_irq), 0);
        chk("t1_rst_ovf",   32'(o_rx_ovf), 0);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        step(1'b1, 8'hA5, 1'b0, 1'b0);
        chk("t1_readback", 32'(o_rx_data), 32'hA5);
        chk("t1_count1", 32'(o_rx_count), 1);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        chk("t1_empty", 32'(o_rx_empty), 1);

        // 2: ordering and pointer wrap
        for (int i = 0; i < 16; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
        chk("t2_full", 32'(o_rx_full), 1);
        chk("t2_count16", 32'(o_rx_count), 16);
        for (int i = 0; i < 16; i++) begin
            chk("t2_order_a", 32'(o_rx_data), 32'(i));
            step(1'b0, 8'h00, 1'b1, 1'b0);
        end
        for (int i = 0; i < 8; i++) step(1'b1, 8'(8'h10 + i), 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            chk("t2_order_b", 32'(o_rx_data), 32'(8'h10 + i));
            step(1'b0, 8'h00, 1'b1, 1'b0);
        end
        chk("t2_empty", 32'(o_rx_empty), 1);

        // 3: overflow, clear, clear-vs-overflow, push+pop at full
        for (int i = 0; i < 16; i++) step(1'b1, 8'(8'h20 + i), 1'b0, 1'b0);
        step(1'b1, 8'hEE, 1'b0, 1'b0);
        chk("t3_ovf", 32'(o_rx_ovf), 1);
        chk("t3_count", 32'(o_rx_count), 16);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        chk("t3_clr", 32'(o_rx_ovf), 0);
        step(1'b1, 8'hEE, 1'b0, 1'b1);
        chk("t3_ovf_wins", 32'(o_rx_ovf), 1);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        step(1'b1, 8'h30, 1'b1, 1'b0);
        chk("t3_pushpop_ovf", 32'(o_rx_ovf), 0);
        chk("t3_pushpop_cnt", 32'(o_rx_count), 16);
        for (int i = 0; i < 16; i++) begin
            chk("t3_drain", 32'(o_rx_data), (i < 15) ? 32'(8'h21 + i) : 32'h30);
            step(1'b0, 8'h00, 1'b1, 1'b0);
        end

        // 4: threshold IRQ
        i_irq_en = 1'b1;
        for (int i = 0; i < 7; i++) step(1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
        idle(1);
        chk("t4_irq_7", 32'(o_rx_irq), 0);
        step(1'b1, 8'h47, 1'b0, 1'b0);
        chk("t4_irq_8_same", 32'(o_rx_irq), 0);
        idle(1);
        chk("t4_irq_8_next", 32'(o_rx_irq), 1);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        chk("t4_irq_pop_same", 32'(o_rx_irq), 1);
        idle(1);
        chk("t4_irq_pop_next", 32'(o_rx_irq), 0);
        for (int i = 0; i < 7; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
        chk("t4_empty", 32'(o_rx_empty), 1);

        // 5: idle timeout, clear, restart, drain
        step(1'b1, 8'h51, 1'b0, 1'b0);
        step(1'b1, 8'h52, 1'b0, 1'b0);
        idle(TO);
        chk("t5_irq_before", 32'(o_rx_irq), 0);
        idle(1);
        chk("t5_irq_at", 32'(o_rx_irq), 1);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        chk("t5_clr_same", 32'(o_rx_irq), 1);
        idle(1);
        chk("t5_clr_next", 32'(o_rx_irq), 0);
        step(1'b1, 8'h53, 1'b0, 1'b0);
        idle(TO - 3);
        step(1'b1, 8'h54, 1'b0, 1'b0);
        idle(3);
        chk("t5_restart_noirq", 32'(o_rx_irq), 0);
        idle(TO - 3);
        chk("t5_restart_before", 32'(o_rx_irq), 0);
        idle(1);
        chk("t5_restart_at", 32'(o_rx_irq), 1);
        for (int i = 0; i < 4; i++) begin
            chk("t5_drain", 32'(o_rx_data), 32'(8'h51 + i));
            step(1'b0, 8'h00, 1'b1, 1'b0);
        end
        chk("t5_drain_same", 32'(o_rx_irq), 1);
        idle(1);
        chk("t5_drain_next", 32'(o_rx_irq), 0);

        // 6: push+pop on empty, pop on empty
        i_irq_en = 1'b0;
        step(1'b1, 8'h66, 1'b1, 1'b0);
        chk("t6_count", 32'(o_rx_count), 1);
        chk("t6_data", 32'(o_rx_data), 32'h66);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        chk("t6_rd_empty_cnt", 32'(o_rx_count), 0);
        chk("t6_rd_empty_emp", 32'(o_rx_empty), 1);
        chk("t6_rd_empty_ovf", 32'(o_rx_ovf), 0);
        chk("t6_rd_empty_data", 32'(o_rx_data), 0);
        idle(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
